// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arith_pkg
// Description : Shared constants for the sequential arithmetic unit
//               (divider and shift-add multiplier).
// Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

    localparam int c_DEF_WIDTH = 32;

    localparam int c_STATE_W = 2;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE   = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_CALC   = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_FINISH = 2'd2;

endpackage : arith_pkg
`default_nettype wire

// File: rtl/div_control.sv
`default_nettype none
// ============================================================================
// Module      : div_control
// Description : Sequencer for the restoring divider: start accept, iteration
//               counter, busy/done handshake and datapath strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module div_control
    import arith_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_div_zero,
    output logic o_load,
    output logic o_step,
    output logic o_finish,
    output logic o_busy,
    output logic o_done
);

    localparam logic [CNT_W-1:0] c_CNT_END = CNT_W'(WIDTH);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic                 w_last;
    logic                 r_busy;
    logic                 r_done;

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_last    = (w_cnt_inc == c_CNT_END);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (i_start) begin
                    w_next_state = i_div_zero ? c_ST_FINISH : c_ST_CALC;
                end
            end
            c_ST_CALC: begin
                if (w_last) begin
                    w_next_state = c_ST_FINISH;
                end
            end
            c_ST_FINISH: w_next_state = c_ST_IDLE;
            default:     w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        o_load   = 1'b0;
        o_step   = 1'b0;
        o_finish = 1'b0;
        case (r_state)
            c_ST_IDLE:   o_load   = i_start;
            c_ST_CALC:   o_step   = 1'b1;
            c_ST_FINISH: o_finish = 1'b1;
            default: begin
                o_load   = 1'b0;
                o_step   = 1'b0;
                o_finish = 1'b0;
            end
        endcase
    end

    // busy spans the done cycle; a start accepted in that cycle keeps it high
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= o_finish;
            if (o_load) begin
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else begin
                if (o_step) begin
                    r_cnt <= w_cnt_inc;
                end
                if (r_done) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule : div_control
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Restoring shift-subtract unsigned divider, one quotient bit
//               per clock, MSB first, with start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    logic             w_load;
    logic             w_step;
    logic             w_finish;
    logic             w_div_zero;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;

    logic [WIDTH:0]   w_r_sh;
    logic [WIDTH-1:0] w_q_sh;
    logic [WIDTH:0]   w_t;
    logic             w_fits;

    assign w_div_zero = (divisor == '0);

    // The partial remainder stays below the divisor between steps, so only
    // the shifted working value needs the extra bit to keep the borrow.
    assign w_r_sh = {r_r, r_q[WIDTH-1]};
    assign w_q_sh = {r_q[WIDTH-2:0], 1'b0};
    assign w_t    = w_r_sh - {1'b0, r_dvsr};
    assign w_fits = ~w_t[WIDTH];

    div_control #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .i_clk      (CLK),
        .i_rst_n    (RST_N),
        .i_start    (start),
        .i_div_zero (w_div_zero),
        .o_load     (w_load),
        .o_step     (w_step),
        .o_finish   (w_finish),
        .o_busy     (busy),
        .o_done     (done)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_q    <= '0;
            r_r    <= '0;
            r_dvsr <= '0;
            r_dbz  <= 1'b0;
        end else if (w_load) begin
            r_dvsr <= divisor;
            r_dbz  <= w_div_zero;
            if (w_div_zero) begin
                r_q <= '1;
                r_r <= dividend;
            end else begin
                r_q <= dividend;
                r_r <= '0;
            end
        end else if (w_step) begin
            if (w_fits) begin
                r_r <= w_t[WIDTH-1:0];
                r_q <= w_q_sh | WIDTH'(1);
            end else begin
                r_r <= w_r_sh[WIDTH-1:0];
                r_q <= w_q_sh;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_quot <= '0;
            r_rem  <= '0;
        end else if (w_finish) begin
            r_quot <= r_q;
            r_rem  <= r_r;
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule : seq_divider
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider (WIDTH=8) with an
//               arithmetic reference model and directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(W)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: results come from plain / and %, timing from the
    // documented latencies counted in clock edges after the accepting edge.
    bit           m_inflight = 1'b0;
    int           m_left     = 0;
    logic [W-1:0] m_pq = '0, m_pr = '0;
    logic [W-1:0] m_q  = '0, m_r  = '0;
    logic         m_dbz = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    bit           m_acc, m_done_n;

    initial forever begin
        @(posedge CLK or negedge RST_N);
        if (!RST_N) begin
            m_inflight = 1'b0; m_left = 0;
            m_q = '0; m_r = '0; m_dbz = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        end else begin
            m_acc    = start && !m_inflight;
            m_done_n = 1'b0;
            if (m_inflight) begin
                m_left--;
                if (m_left == 0) begin
                    m_inflight = 1'b0;
                    m_q = m_pq;
                    m_r = m_pr;
                    m_done_n = 1'b1;
                end
            end
            if (m_done && !m_acc) m_busy = 1'b0;
            if (m_acc) begin
                m_inflight = 1'b1;
                m_busy     = 1'b1;
                m_dbz      = (divisor == 0);
                m_left     = (divisor == 0) ? 1 : W + 1;
                m_pq       = (divisor == 0) ? '1 : dividend / divisor;
                m_pr       = (divisor == 0) ? dividend : dividend % divisor;
            end
            m_done = m_done_n;
        end
    end

    initial forever begin
        @(negedge CLK);
        chk("cyc_done", done, m_done);
        chk("cyc_busy", busy, m_busy);
        chk("cyc_quotient", quotient, m_q);
        chk("cyc_remainder", remainder, m_r);
        chk("cyc_div_by_zero", div_by_zero, m_dbz);
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge CLK);
        start    = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge CLK);
            if (done === 1'b1) begin
                lat = j;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: actual=no done required=done within 40 cycles at %0t", $time);
        end
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                             input logic z);
        chk({tag, "_quotient"}, quotient, q);
        chk({tag, "_remainder"}, remainder, r);
        chk({tag, "_div_by_zero"}, div_by_zero, z);
    endtask

    task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic z,
                       input int exp_lat);
        int lat;
        @(negedge CLK);
        start_op(a, b);
        wait_done(lat);
        chk({tag, "_latency"}, lat, exp_lat);
        check_res(tag, q, r, z);
    endtask

    logic [W-1:0] va[6] = '{8'd200, 8'd255, 8'd1, 8'd128, 8'd0, 8'd7};
    logic [W-1:0] vb[6] = '{8'd10,  8'd255, 8'd2, 8'd3,   8'd5, 8'd0};
    logic [W-1:0] vq[6] = '{8'd20,  8'd1,   8'd0, 8'd42,  8'd0, 8'hFF};
    logic [W-1:0] vr[6] = '{8'd0,   8'd0,   8'd1, 8'd2,   8'd0, 8'd7};

    initial begin
        int lat;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div_by_zero", div_by_zero, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        run("basic", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9);
        run("div_one", 8'hFF, 8'd1, 8'hFF, 8'd0, 1'b0, 9);
        run("small", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9);
        run("div_zero", 8'd42, 8'd0, 8'hFF, 8'd42, 1'b1, 1);
        for (int i = 0; i < 6; i++) begin
            run("table", va[i], vb[i], vq[i], vr[i], vb[i] == 0, (vb[i] == 0) ? 1 : 9);
        end

        // reset in the middle of the fourth iteration
        @(negedge CLK);
        start_op(8'd200, 8'd3);
        repeat (3) @(negedge CLK);
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("rstmid_quotient", quotient, 0);
        chk("rstmid_remainder", remainder, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_div_by_zero", div_by_zero, 0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (12) @(negedge CLK);
        run("post_rst", 8'd200, 8'd3, 8'd66, 8'd2, 1'b0, 9);

        // start and operand changes during CALC must not disturb the result
        @(negedge CLK);
        start_op(8'd100, 8'd7);
        repeat (3) @(negedge CLK);
        dividend = 8'h11;
        divisor  = 8'h00;
        start    = 1'b1;
        @(negedge CLK);
        start    = 1'b0;
        wait_done(lat);
        check_res("ignored_start", 8'd14, 8'd2, 1'b0);

        // back-to-back: next start raised in the done cycle
        @(negedge CLK);
        start_op(8'd200, 8'd3);
        wait_done(lat);
        check_res("b2b_first", 8'd66, 8'd2, 1'b0);
        start_op(8'd255, 8'd16);
        wait_done(lat);
        chk("b2b_second_latency", lat, 9);
        check_res("b2b_second", 8'd15, 8'd15, 1'b0);

        repeat (4) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_divider
`default_nettype wire
